ondra_printer_port_rx: RTL
==========================

// Module: ondra_printer_port_rx
// PURPOSE
//  Printer-side responder for the Ondra parallel (Centronics-style) port.
//  Samples the 8-bit data bus on the falling edge of NON_STB and drives BUSY back to the CPU keyboard port.
//  Pulses ACK_n after each byte and queues received bytes in a FIFO.
//  Downstream consumers (printer emulation, UART bridge, SD logger) drain the FIFO through a valid/ready sink.
// PARAMETERS
//  FIFO_AW   4   log2 FIFO depth (16 entries)
//  BUSY_MIN  16  minimum BUSY high time, clk_sys cycles, counted from byte capture
//  ACK_LEN   8   ACK_n low pulse length, clk_sys cycles
// PORTS
//  clk_sys    in   1  system clock (8 MHz); single clock domain
//  reset      in   1  synchronous, active-high
//  prn_data   in   8  parallel data from the core latch (stable while NON_STB low)
//  NON_STB    in   1  strobe, active-low, asynchronous to clk_sys
//  BUSY       out  1  to core keyboard port bit 5; 1 = do not strobe
//  ACK_n      out  1  acknowledge, active-low pulse
//  out_data   out  8  FIFO head byte (first-word fall-through)
//  out_valid  out  1  FIFO not empty
//  out_ready  in   1  sink accepts out_data when out_valid & out_ready
//  fifo_level out  FIFO_AW+1  current occupancy, 0..2**FIFO_AW
// BEHAVIOUR
//  Reset: BUSY=0, ACK_n=1, out_valid=0, fifo_level=0, FSM=IDLE, synchroniser=2'b11.
//  NON_STB passes a 2-FF synchroniser plus an edge register. A falling edge is detected in cycle N.
//  FSM IDLE -> CAPT -> HOLD -> ACK -> IDLE:
//   IDLE: BUSY=0. Falling edge in cycle N -> CAPT.
//   CAPT (N+1): prn_data is written to the FIFO. BUSY=1 from N+1. Busy counter is loaded with BUSY_MIN-1. -> HOLD.
//   HOLD: counter decrements. Leaves when counter==0 AND fifo_level < 2**FIFO_AW. A full FIFO stretches BUSY indefinitely.
//   ACK: BUSY=1, ACK_n=0 for exactly ACK_LEN cycles, then -> IDLE (BUSY=0 in the following cycle).
//  FIFO full in CAPT: the write is accepted only if a pop happens in the same cycle. Otherwise the byte is dropped and the FSM continues normally.
//  Simultaneous push+pop: level unchanged. Pop on empty: ignored.
//  Pointers wrap mod 2**FIFO_AW. fifo_level is a separate counter and never exceeds 2**FIFO_AW.
//  Falling edges detected outside IDLE are protocol violations. They are ignored: no capture, no state change.
//  Reset mid-transfer: FSM to IDLE, FIFO flushed, BUSY/ACK_n released in the cycle after reset is sampled.
//  Latency: pin edge to FIFO write = 4 cycles; out_valid rises the cycle after the write.
// CONFIGURATION
//  Macro ONDRA_PRN_DROP_STATS_EN:
//   defined: adds outputs drop_cnt[7:0] and overflow (sticky).
//    drop_cnt increments (saturating at 255) on each dropped CAPT write and each ignored non-IDLE edge.
//    overflow sets on any drop. Both are cleared only by reset.
//   undefined: the ports are absent and drops are silent. All other behaviour is identical.
// STRUCTURE
//  ondra_prn_defs.vh holds shared constants:
//   FSM state encodings ST_IDLE/ST_CAPT/ST_HOLD/ST_ACK (2 bits).
//   Default widths, so the core and the bench decode states identically.
//  One sub-module, ondra_byte_fifo: synchronous FWFT FIFO with push, pop, full, empty and level.
//   It is parameterised by address width and has no knowledge of the protocol.
//  Top level contains the synchroniser, edge detect, FSM, busy/ack counters and optional stats.
// TESTING
//  Single byte: reset, prn_data=8'hA5, NON_STB low 10 cycles -> BUSY=1 from detect+1.
//   ACK_n low 8 cycles, starting 16 cycles after capture.
//   out_data=8'hA5 with out_valid=1. BUSY=0 after ACK.
//  Burst honouring BUSY: host sends 0x00..0x0F, waiting for BUSY=0; out_ready=0 ->
//   fifo_level reaches 16 and BUSY stays 1.
//   Pop one -> HOLD exits and ACK pulse follows.
//   Drain -> bytes 0x00..0x0F in order.
//  Rogue host: second NON_STB falling edge during HOLD -> ignored, fifo_level unchanged.
//   With ONDRA_PRN_DROP_STATS_EN: drop_cnt=1, overflow=1.
//  Full + pop same cycle: FIFO full, force CAPT while out_ready=1 -> byte stored, level stays 16, no drop.
//  Reset in HOLD with level=3 -> next cycle BUSY=0, ACK_n=1, out_valid=0, fifo_level=0.
//  Sink backpressure: toggle out_ready every other cycle across 40 random bytes -> scoreboard matches, no loss, no duplicates.

Source files
------------

// File: rtl/ondra_printer_port_rx_pkg.sv
// Shared constants, FSM state encoding and helpers for the Ondra printer port receiver.
package ondra_printer_port_rx_pkg;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned FIFO_AW_DEF  = 4;
    localparam int unsigned BUSY_MIN_DEF = 16;
    localparam int unsigned ACK_LEN_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_HOLD = 2'd2,
        ST_ACK  = 2'd3
    } prn_state_t;

    // Saturating 8-bit add of a small increment (0..3).
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = 9'(a) + 9'(b);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/ondra_byte_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy counter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ondra_byte_fifo #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head,
    output logic [AW:0]   level
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; level is tracked separately so full/empty are unambiguous.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ondra_printer_port_rx.sv
// Printer-side responder for the Ondra Centronics-style port: synchronises NON_STB,
// captures a byte on each falling edge, holds BUSY, pulses ACK_n and queues bytes.
// Optional build macro ONDRA_PRN_DROP_STATS_EN adds drop_cnt/overflow outputs.
module ondra_printer_port_rx
    import ondra_printer_port_rx_pkg::*;
#(
    parameter int unsigned FIFO_AW  = FIFO_AW_DEF,
    parameter int unsigned BUSY_MIN = BUSY_MIN_DEF,
    parameter int unsigned ACK_LEN  = ACK_LEN_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [DATA_W-1:0] prn_data,
    input  logic              NON_STB,
    output logic              BUSY,
    output logic              ACK_n,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FIFO_AW:0]  fifo_level
`ifdef ONDRA_PRN_DROP_STATS_EN
    ,
    output logic [7:0]        drop_cnt,
    output logic              overflow
`endif
);

    localparam int unsigned BCW = $clog2(BUSY_MIN + 1);
    localparam int unsigned ACW = $clog2(ACK_LEN + 1);

    prn_state_t     state;
    logic           stb_s1;
    logic           stb_s2;
    logic           stb_d;
    logic           fall_c;
    logic [BCW-1:0] busy_cnt;
    logic [ACW-1:0] ack_cnt;
    logic           fifo_full;
    logic           fifo_empty;

    assign fall_c    = stb_d && !stb_s2;
    assign out_valid = !fifo_empty;

    // Two-flop synchroniser plus edge register for the asynchronous strobe.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stb_s1 <= 1'b1;
            stb_s2 <= 1'b1;
            stb_d  <= 1'b1;
        end else begin
            stb_s1 <= NON_STB;
            stb_s2 <= stb_s1;
            stb_d  <= stb_s2;
        end
    end

    // Handshake FSM with registered BUSY/ACK_n; edges seen outside IDLE are ignored.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= ST_IDLE;
            BUSY     <= 1'b0;
            ACK_n    <= 1'b1;
            busy_cnt <= '0;
            ack_cnt  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    BUSY  <= 1'b0;
                    ACK_n <= 1'b1;
                    if (fall_c) begin
                        state <= ST_CAPT;
                        BUSY  <= 1'b1;
                    end
                end
                ST_CAPT: begin
                    busy_cnt <= BCW'(BUSY_MIN - 1);
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (busy_cnt != '0) begin
                        busy_cnt <= busy_cnt - BCW'(1);
                    end else if (!fifo_full) begin
                        state   <= ST_ACK;
                        ACK_n   <= 1'b0;
                        ack_cnt <= ACW'(ACK_LEN - 1);
                    end
                end
                ST_ACK: begin
                    if (ack_cnt == '0) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                        ACK_n <= 1'b1;
                    end else begin
                        ack_cnt <= ack_cnt - ACW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    ACK_n <= 1'b1;
                end
            endcase
        end
    end

    ondra_byte_fifo #(
        .AW (FIFO_AW),
        .DW (DATA_W)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .push      (state == ST_CAPT),
        .push_data (prn_data),
        .pop       (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_data),
        .level     (fifo_level)
    );

`ifdef ONDRA_PRN_DROP_STATS_EN
    logic       capt_drop;
    logic       edge_ign;
    logic [1:0] drop_inc;

    assign capt_drop = (state == ST_CAPT) && fifo_full && !(out_ready && !fifo_empty);
    assign edge_ign  = fall_c && (state != ST_IDLE);
    assign drop_inc  = 2'({1'b0, capt_drop}) + 2'({1'b0, edge_ign});

    // Saturating drop counter and sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop_inc != 2'd0) begin
            drop_cnt <= sat_add8(drop_cnt, drop_inc);
            overflow <= 1'b1;
        end
    end
`endif

endmodule
